i2c_data_fifo: RTL and testbench

Parameterised synchronous FIFO that buffers byte data between the APB register interface and the I2C master/slave engines. One instance sits upstream of the master as the TX FIFO: the engine reads `tx_data` and pops it with `TX_read_enable`. A second instance sits downstream as the RX FIFO: the engine pushes with `RX_write_enable` and watches `RX_fifo_full` / `RX_fifo_almost_full`. The output is first-word-fall-through, so the engine sees the head byte without issuing a read first.

---
 rtl/i2c_data_fifo.sv | 94 +++++++++
 tb/tb_i2c_data_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/i2c_data_fifo.sv
// First-word-fall-through byte FIFO between the APB register block and the I2C engines.
// Count-based flags; overflow/underflow rejections are reported as registered one-cycle pulses.
module i2c_data_fifo #(
  parameter int unsigned WIDTH             = 8,
  parameter int unsigned DEPTH             = 32,
  parameter int unsigned ALMOST_FULL_LEVEL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     write_enable,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     read_enable,
  output logic [WIDTH-1:0]         read_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_set,
  output logic                     underflow_set
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc, rd_acc;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(ALMOST_FULL_LEVEL));
  assign count       = count_q;
  assign read_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow_set  = ovf_q;
  assign underflow_set = udf_q;

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign wr_acc = write_enable && (!full || read_enable);
  assign rd_acc = read_enable && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      ovf_d = write_enable && !wr_acc;
      udf_d = read_enable && !rd_acc;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage; clear only rewinds pointers and leaves contents intact.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (!clear && wr_acc) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

endmodule

// File: tb/tb_i2c_data_fifo.sv
// Scoreboard bench for i2c_data_fifo: a queue-based reference model predicts the post-edge
// outputs of every driven cycle; an independent monitor compares them one step after the edge.
module tb_i2c_data_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AFL   = DEPTH - 1;

  logic                   clk = 1'b0;
  logic                   n_rst;
  logic                   clear, write_enable, read_enable;
  logic [WIDTH-1:0]       write_data;
  logic [WIDTH-1:0]       read_data;
  logic                   empty, full, almost_full;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow_set, underflow_set;

  i2c_data_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear),
    .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(read_data),
    .empty(empty), .full(full), .almost_full(almost_full), .count(count),
    .overflow_set(overflow_set), .underflow_set(underflow_set)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cnt;
    int unsigned rd;
    bit e, f, af, ovf, udf;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  model[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic void check(string nm, int unsigned act, int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference behaviour: FIFO as a bounded queue, evaluated once per clock.
  task automatic cyc(input bit we, input logic [7:0] wd, input bit re, input bit clr);
    exp_t x;
    bit   wacc, racc;
    @(negedge clk);
    write_enable = we; write_data = wd; read_enable = re; clear = clr;
    x.ovf = 0; x.udf = 0;
    if (clr) begin
      model.delete();
    end else begin
      wacc = we && (model.size() < DEPTH || re);
      racc = re && model.size() > 0;
      if (racc) void'(model.pop_front());
      if (wacc) model.push_back(wd);
      x.ovf = we && !wacc;
      x.udf = re && !racc;
    end
    x.cnt = model.size();
    x.rd  = (model.size() > 0) ? model[0] : 0;
    x.e   = (model.size() == 0);
    x.f   = (model.size() == DEPTH);
    x.af  = (model.size() >= AFL);
    sb.push_back(x);
  endtask

  task automatic push(input logic [7:0] d); cyc(1, d, 0, 0); endtask
  task automatic pop();                    cyc(0, 0, 1, 0); endtask
  task automatic idle();                   cyc(0, 0, 0, 0); endtask

  task automatic check_reset_outputs(string tag);
    check({tag, ".count"}, count, 0);
    check({tag, ".empty"}, empty, 1);
    check({tag, ".full"}, full, 0);
    check({tag, ".almost_full"}, almost_full, 0);
    check({tag, ".read_data"}, read_data, 0);
    check({tag, ".overflow_set"}, overflow_set, 0);
    check({tag, ".underflow_set"}, underflow_set, 0);
  endtask

  // Monitor: one expectation per driven edge, sampled just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (n_rst && sb.size() > 0) begin
        x = sb.pop_front();
        check("count", count, x.cnt);
        check("read_data", read_data, x.rd);
        check("empty", empty, x.e);
        check("full", full, x.f);
        check("almost_full", almost_full, x.af);
        check("overflow_set", overflow_set, x.ovf);
        check("underflow_set", underflow_set, x.udf);
      end
    end
  end

  initial begin
    int budget;
    n_rst = 1'b0; clear = 0; write_enable = 0; read_enable = 0; write_data = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    n_rst = 1'b1;

    // basic ordering
    push(8'h11); push(8'h22); push(8'h33);
    repeat (3) pop();
    idle();

    // fill, overflow, drain
    for (int i = 0; i < 32; i++) push(8'(5 * i));
    push(8'hEE);
    idle();
    repeat (32) pop();

    // pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 20; i++) push(8'(i + 100 + r * 20));
      repeat (20) pop();
    end

    // simultaneous push/pop when full and when empty
    for (int i = 0; i < 32; i++) push(8'($urandom));
    cyc(1, 8'hAA, 1, 0);
    repeat (32) pop();
    cyc(1, 8'h5C, 1, 0);
    pop();

    // underflow, then clear with concurrent push
    pop(); idle();
    for (int i = 0; i < 10; i++) push(8'(i + 1));
    cyc(1, 8'h77, 1, 1);
    idle();
    cyc(1, 8'h99, 0, 0);
    pop();

    // randomized traffic with occasional clear
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
          $urandom_range(0, 199) == 0);
    repeat (40) pop();

    // asynchronous reset mid-burst
    for (int i = 0; i < 7; i++) push(8'(i + 200));
    @(posedge clk); #3;
    n_rst = 1'b0; write_enable = 0; read_enable = 0; clear = 0;
    #1 check_reset_outputs("async_rst");
    model.delete();
    @(negedge clk);
    n_rst = 1'b1;
    idle();
    push(8'h01);
    pop();
    idle();

    budget = 10;
    while (sb.size() > 0 && budget > 0) begin @(posedge clk); budget--; end
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
